// File: rtl/ddrx_pkg.sv
// ddrx_pkg: types and helpers shared by the DDRx front-end blocks.
//   arb_state_e  - command arbiter FSM states
//   nasti_cmd_t  - command word layout {is_write, id, len, addr} at the default widths
//   cmd_width()  - command word width for arbitrary address/id/len widths
package ddrx_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    PUSH = 1'b1
  } arb_state_e;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_ID_WIDTH   = 4;
  localparam int DEF_LEN_WIDTH  = 8;

  typedef struct packed {
    logic                      is_write;
    logic [DEF_ID_WIDTH-1:0]   id;
    logic [DEF_LEN_WIDTH-1:0]  len;
    logic [DEF_ADDR_WIDTH-1:0] addr;
  } nasti_cmd_t;

  function automatic int cmd_width(input int addr_w, input int id_w, input int len_w);
    return 1 + id_w + len_w + addr_w;
  endfunction

endpackage

// File: rtl/arb_age_cnt.sv
// arb_age_cnt: saturating age counter for the pending write request.
//   clk, rst  - clock, synchronous active-high reset
//   inc       - count one lost arbitration (saturates at C_LIMIT)
//   clr       - clear to zero (write was granted); wins over inc
//   age       - current count
//   expired   - age has reached C_LIMIT
module arb_age_cnt #(
  parameter  int C_LIMIT = 4,
  localparam int W       = $clog2(C_LIMIT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] age,
  output logic         expired
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      age <= '0;
    end else if (inc && (age < W'(C_LIMIT))) begin
      age <= age + W'(1);
    end
  end

  assign expired = (age >= W'(C_LIMIT));

endmodule

// File: rtl/nasti_cmd_arbiter.sv
// nasti_cmd_arbiter: merges NASTI AR and AW requests into one command word per
// grant and pushes it into the scheduler command sfifo. Reads win unless a
// pending write has lost C_AGE_LIMIT arbitrations. Commands in flight are
// capped at C_MAX_OUTSTANDING.
//
// state | meaning
// IDLE  | may grant one request when the fifo has room and the in-flight cap allows
// PUSH  | fifo_wren asserted with the word registered on the previous grant
//
// Ports:
//   clk, rst                              clock, synchronous active-high reset
//   ar_valid/ar_ready/ar_id/ar_addr/ar_len read address channel
//   aw_valid/aw_ready/aw_id/aw_addr/aw_len write address channel
//   fifo_wdata, fifo_wren, fifo_wfull     sfifo write side
//   cmd_done                              downstream retired one command
//   outstanding                           commands pushed but not yet retired
//   rd_grant_cnt, wr_grant_cnt, age_force_cnt
//                                         grant statistics, present only with NASTI_ARB_STATS_EN
module nasti_cmd_arbiter
  import ddrx_pkg::*;
#(
  parameter  int C_ADDR_WIDTH      = 32,
  parameter  int C_ID_WIDTH        = 4,
  parameter  int C_LEN_WIDTH       = 8,
  parameter  int C_AGE_LIMIT       = 4,
  parameter  int C_MAX_OUTSTANDING = 8,
  localparam int C_CMD_WIDTH       = cmd_width(C_ADDR_WIDTH, C_ID_WIDTH, C_LEN_WIDTH),
  localparam int OW                = $clog2(C_MAX_OUTSTANDING + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ar_valid,
  output logic                    ar_ready,
  input  logic [C_ID_WIDTH-1:0]   ar_id,
  input  logic [C_ADDR_WIDTH-1:0] ar_addr,
  input  logic [C_LEN_WIDTH-1:0]  ar_len,
  input  logic                    aw_valid,
  output logic                    aw_ready,
  input  logic [C_ID_WIDTH-1:0]   aw_id,
  input  logic [C_ADDR_WIDTH-1:0] aw_addr,
  input  logic [C_LEN_WIDTH-1:0]  aw_len,
  output logic [C_CMD_WIDTH-1:0]  fifo_wdata,
  output logic                    fifo_wren,
  input  logic                    fifo_wfull,
  input  logic                    cmd_done,
`ifdef NASTI_ARB_STATS_EN
  output logic [31:0]             rd_grant_cnt,
  output logic [31:0]             wr_grant_cnt,
  output logic [31:0]             age_force_cnt,
`endif
  output logic [OW-1:0]           outstanding
);

  arb_state_e state_q, state_d;
  logic       can_acc;
  logic       grant_r, grant_w;
  logic       age_expired;
  logic       dec_ok;

  arb_age_cnt #(.C_LIMIT(C_AGE_LIMIT)) u_age (
    .clk    (clk),
    .rst    (rst),
    .inc    ((state_q == IDLE) && aw_valid && !grant_w),
    .clr    (grant_w),
    .age    (),
    .expired(age_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Ready is only raised for the granted channel, so a grant is already a handshake.
  always_comb begin
    state_d   = state_q;
    can_acc   = 1'b0;
    grant_r   = 1'b0;
    grant_w   = 1'b0;
    fifo_wren = 1'b0;
    case (state_q)
      IDLE: begin
        can_acc = !fifo_wfull && (outstanding < OW'(C_MAX_OUTSTANDING)) && !rst;
        grant_w = can_acc && aw_valid && (!ar_valid || age_expired);
        grant_r = can_acc && ar_valid && !grant_w;
        if (grant_r || grant_w) state_d = PUSH;
      end
      PUSH: begin
        fifo_wren = !rst;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ar_ready = grant_r;
  assign aw_ready = grant_w;

  always_ff @(posedge clk) begin
    if (rst)          fifo_wdata <= '0;
    else if (grant_w) fifo_wdata <= {1'b1, aw_id, aw_len, aw_addr};
    else if (grant_r) fifo_wdata <= {1'b0, ar_id, ar_len, ar_addr};
  end

  // A stray cmd_done with nothing in flight is dropped rather than wrapping the count.
  assign dec_ok = cmd_done && (outstanding != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= '0;
    end else if (fifo_wren && !dec_ok) begin
      outstanding <= outstanding + OW'(1);
    end else if (!fifo_wren && dec_ok) begin
      outstanding <= outstanding - OW'(1);
    end
  end

`ifdef NASTI_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_grant_cnt  <= '0;
      wr_grant_cnt  <= '0;
      age_force_cnt <= '0;
    end else begin
      if (grant_r) rd_grant_cnt <= rd_grant_cnt + 32'd1;
      if (grant_w) wr_grant_cnt <= wr_grant_cnt + 32'd1;
      if (grant_w && ar_valid && age_expired) age_force_cnt <= age_force_cnt + 32'd1;
    end
  end
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(cmd_done && (outstanding == '0)))
        else $error("cmd_done with no command outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_nasti_cmd_arbiter.sv
module tb_nasti_cmd_arbiter;
  import ddrx_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ar_valid, aw_valid;
  logic        ar_ready, aw_ready;
  logic [3:0]  ar_id, aw_id;
  logic [31:0] ar_addr, aw_addr;
  logic [7:0]  ar_len, aw_len;
  logic [44:0] fifo_wdata;
  logic        fifo_wren, fifo_wfull, cmd_done;
  logic [3:0]  outstanding;
`ifdef NASTI_ARB_STATS_EN
  logic [31:0] rd_grant_cnt, wr_grant_cnt, age_force_cnt;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nasti_cmd_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .ar_valid   (ar_valid),
    .ar_ready   (ar_ready),
    .ar_id      (ar_id),
    .ar_addr    (ar_addr),
    .ar_len     (ar_len),
    .aw_valid   (aw_valid),
    .aw_ready   (aw_ready),
    .aw_id      (aw_id),
    .aw_addr    (aw_addr),
    .aw_len     (aw_len),
    .fifo_wdata (fifo_wdata),
    .fifo_wren  (fifo_wren),
    .fifo_wfull (fifo_wfull),
    .cmd_done   (cmd_done),
`ifdef NASTI_ARB_STATS_EN
    .rd_grant_cnt (rd_grant_cnt),
    .wr_grant_cnt (wr_grant_cnt),
    .age_force_cnt(age_force_cnt),
`endif
    .outstanding(outstanding)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change 1 ns after the rising edge; outputs are sampled 3 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts in an IDLE cycle, returns 1 ns into the PUSH cycle of the grant.
  task automatic push_ar(input logic [3:0] id);
    int n;
    n        = 0;
    ar_valid = 1'b1;
    ar_id    = id;
    ar_addr  = 32'h100 * id;
    ar_len   = 8'd1;
    #3;
    while (!ar_ready && n < 20) begin
      tick();
      #3;
      n++;
    end
    chk("push_ar_ready", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    int   k, cyc, hits;
    logic last_wren;
    nasti_cmd_t exp_cmd;

    rst = 1'b1;
    ar_valid = 1'b1; aw_valid = 1'b1;
    ar_id = 4'd1; aw_id = 4'd2;
    ar_addr = 32'h10; aw_addr = 32'h20;
    ar_len = 8'd0; aw_len = 8'd0;
    fifo_wfull = 1'b0; cmd_done = 1'b0;

    // 1: reset with both valids asserted
    for (int i = 0; i < 2; i++) begin
      tick();
      #3;
      chk("rst_ar_ready", ar_ready, 0);
      chk("rst_aw_ready", aw_ready, 0);
      chk("rst_wren", fifo_wren, 0);
      chk("rst_outstanding", outstanding, 0);
    end
    chk("rst_wdata", fifo_wdata, 0);
    tick();
    rst = 1'b0; ar_valid = 1'b0; aw_valid = 1'b0;
    tick();

    // 2: single read, latency of push and count
    ar_valid = 1'b1; ar_id = 4'd3; ar_addr = 32'h1000; ar_len = 8'd7;
    #3;
    chk("t2_ar_ready", ar_ready, 1);
    chk("t2_aw_ready", aw_ready, 0);
    tick();
    ar_valid = 1'b0;
    #3;
    exp_cmd = '{is_write: 1'b0, id: 4'd3, len: 8'd7, addr: 32'h1000};
    chk("t2_wren", fifo_wren, 1);
    chk("t2_wdata", fifo_wdata, exp_cmd);
    chk("t2_out_n1", outstanding, 0);
    tick();
    #3;
    chk("t2_out_n2", outstanding, 1);
    chk("t2_wren_off", fifo_wren, 0);
    chk("t2_wdata_hold", fifo_wdata, exp_cmd);
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    #3;
    chk("t2_done", outstanding, 0);

    // 3: both channels held valid, write aging
    tick();
    ar_valid = 1'b1; aw_valid = 1'b1;
    ar_id = 4'd5; aw_id = 4'd9; aw_addr = 32'h2000; aw_len = 8'd3;
    k = 0; cyc = 0; last_wren = 1'b0;
    while (k < 10 && cyc < 60) begin
      cmd_done = last_wren;
      #3;
      last_wren = fifo_wren;
      if (ar_ready || aw_ready) begin
        chk("t3_one_hot", {63'd0, ar_ready & aw_ready}, 0);
        chk("t3_grant", {63'd0, aw_ready}, {63'd0, (k == 4 || k == 9)});
        k++;
      end
      tick();
      cyc++;
    end
    chk("t3_count", k, 10);
    ar_valid = 1'b0; aw_valid = 1'b0; cmd_done = 1'b0;
    #3;
    exp_cmd = '{is_write: 1'b1, id: 4'd9, len: 8'd3, addr: 32'h2000};
    chk("t3_last_word", fifo_wdata, exp_cmd);
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    #3;
    chk("t3_out", outstanding, 0);

    // 4: fifo full blocks acceptance
    tick();
    ar_valid = 1'b1; fifo_wfull = 1'b1;
    hits = 0;
    repeat (10) begin
      #3;
      if (ar_ready) hits++;
      tick();
    end
    chk("t4_blocked", hits, 0);
    fifo_wfull = 1'b0;
    #3;
    chk("t4_release", ar_ready, 1);
    tick();
    ar_valid = 1'b0;
    tick();
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    #3;
    chk("t4_out", outstanding, 0);

    // 5: outstanding cap
    tick();
    for (int i = 0; i < 8; i++) begin
      push_ar(4'(i));
      tick();
    end
    ar_valid = 1'b1;
    #3;
    chk("t5_out8", outstanding, 8);
    chk("t5_capped", ar_ready, 0);
    repeat (3) tick();
    #3;
    chk("t5_still_capped", ar_ready, 0);
    tick();
    cmd_done = 1'b1;
    #3;
    chk("t5_capped_done_cycle", ar_ready, 0);
    tick();
    cmd_done = 1'b0;
    #3;
    chk("t5_out7", outstanding, 7);
    chk("t5_ninth", ar_ready, 1);
    tick();
    ar_valid = 1'b0; cmd_done = 1'b1;
    #3;
    chk("t5_ninth_wren", fifo_wren, 1);
    tick();
    cmd_done = 1'b0;
    #3;
    chk("t5_coincident", outstanding, 7);
    cmd_done = 1'b1;
    repeat (7) tick();
    cmd_done = 1'b0;
    #3;
    chk("t5_drained", outstanding, 0);

    // 6: reset during PUSH
    tick();
    push_ar(4'd1);
    tick();
    push_ar(4'd2);
    #3;
    chk("t6_pre_out", outstanding, 1);
    rst = 1'b1;
    #0;
    #1;
    chk("t6_wren_rst", fifo_wren, 0);
    tick();
    rst = 1'b0;
    #3;
    chk("t6_out", outstanding, 0);
    chk("t6_wren_after", fifo_wren, 0);
    chk("t6_wdata", fifo_wdata, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
